mux_arb_n: RTL



---
 rtl/mux_arb_n_pkg.sv | 22 ++
 rtl/mux_arb_n_if.sv | 35 +++
 rtl/mux_arb_n_rr_pick.sv | 44 ++++
 rtl/mux_arb_n.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mux_arb_n_pkg.sv
// mux_arb_n_pkg: shared definitions for the arbitrated multiplexer.
//   - lock_state_e : packet-lock FSM encodings (ARB_IDLE / ARB_LOCKED)
//   - range limits for the CHANNELS / WIDTH parameters
//   - next_ptr()   : round-robin pointer successor with wrap
package mux_arb_n_pkg;

    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 64;
    localparam int CHANNELS_MIN = 2;
    localparam int CHANNELS_MAX = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_state_e;

    // Successor of channel g in an n-channel ring; n need not be a power of two.
    function automatic int next_ptr(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// mux_arb_if: producer-side and consumer-side handshake bundle of mux_arb_n.
//   in_valid/in_ready/in_last [CHANNELS] : per-channel request, accept, end-of-packet
//   in_data [CHANNELS*WIDTH]             : channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready                  : registered output handshake
//   out_data/out_chan/out_last           : registered beat, source index, end marker
// Modports: slave = the multiplexer, master = the surrounding producers/consumer.
interface mux_arb_if
    import mux_arb_n_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_chan, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_chan, out_last
    );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req        [CHANNELS] : requesting channels
//   ptr        [SELW]     : highest-priority channel this cycle
//   gnt_onehot [CHANNELS] : one-hot grant (all zero when nothing requests)
//   gnt_idx    [SELW]     : binary index of the grant
//   any                   : at least one request present
module rr_pick
    import mux_arb_n_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [CHANNELS-1:0] gnt_onehot,
    output logic [SELW-1:0]     gnt_idx,
    output logic                any
);

    // Scan ptr..CHANNELS-1 first, then 0..ptr-1. Splitting the scan in two
    // passes gives the wrap without modulo arithmetic, so non-power-of-two
    // channel counts need no special casing. An out-of-range ptr degrades
    // to a plain lowest-index-first scan.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!any && req[c] && (c >= int'(ptr))) begin
                any           = 1'b1;
                gnt_idx       = SELW'(c);
                gnt_onehot[c] = 1'b1;
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (!any && req[c] && (c < int'(ptr))) begin
                any           = 1'b1;
                gnt_idx       = SELW'(c);
                gnt_onehot[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel, W-bit round-robin arbitrated multiplexer with one
// output register stage and valid/ready handshakes on every side.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mux_arb_if.slave (per-channel inputs, registered output)
// Optional feature: define MUX_ARB_LOCK_EN to add a packet-lock FSM that keeps
// the grant on one channel from its first beat until a beat with in_last = 1.
// Without it every beat is arbitrated independently.
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic       clk,
    input  logic       reset,
    mux_arb_if.slave   bus
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
        WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_param
        $error("mux_arb_n: CHANNELS or WIDTH out of range");
    end

    logic                           load;
    logic                           xfer;
    logic                           adv;
    logic                           any;
    logic [CHANNELS-1:0]            req;
    logic [CHANNELS-1:0]            gnt_onehot;
    logic [SELW-1:0]                gnt_idx;
    logic [SELW-1:0]                ptr;
    logic [SELW-1:0]                ptr_next;
    logic [CHANNELS-1:0][WIDTH-1:0] data_v;
    logic [WIDTH-1:0]               sel_data;
    logic                           sel_last;

    logic                           out_valid_q;
    logic [WIDTH-1:0]               out_data_q;
    logic [SELW-1:0]                out_chan_q;
    logic                           out_last_q;

    // The output stage can take a new beat when empty or being drained.
    assign load     = !out_valid_q || bus.out_ready;
    assign xfer     = load && any;
    assign data_v   = bus.in_data;
    assign sel_data = data_v[gnt_idx];
    assign sel_last = bus.in_last[gnt_idx];
    assign ptr_next = (gnt_idx == SELW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;

    assign bus.in_ready  = load ? gnt_onehot : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_last  = out_last_q;

    rr_pick #(.CHANNELS(CHANNELS)) u_pick (
        .req        (req),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

`ifdef MUX_ARB_LOCK_EN
    lock_state_e         state;
    lock_state_e         state_next;
    logic [SELW-1:0]     lock_chan;
    logic [CHANNELS-1:0] lock_mask;

    assign lock_mask = {{(CHANNELS-1){1'b0}}, 1'b1} << lock_chan;

    // Kept outside the FSM block: the grant feeds the FSM through sel_last,
    // so mixing the mask into that block would form a false comb loop.
    assign req = (state == ARB_LOCKED) ? (bus.in_valid & lock_mask) : bus.in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            lock_chan <= '0;
        end else begin
            state <= state_next;
            if (xfer && state == ARB_IDLE)
                lock_chan <= gnt_idx;
        end
    end

    // ptr is frozen for the whole packet and only moves past the locked
    // channel on its closing beat (or on a single-beat packet).
    always_comb begin
        state_next = state;
        adv        = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (xfer) begin
                    if (sel_last) adv        = 1'b1;
                    else          state_next = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (xfer && sel_last) begin
                    state_next = ARB_IDLE;
                    adv        = 1'b1;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end
`else
    assign req = bus.in_valid;
    assign adv = xfer;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            ptr         <= '0;
        end else if (load) begin
            if (any) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_chan_q  <= gnt_idx;
                out_last_q  <= sel_last;
            end else begin
                // Drained with nothing waiting: payload registers keep their value.
                out_valid_q <= 1'b0;
            end
            if (adv)
                ptr <= ptr_next;
        end
    end

endmodule
